// File: rtl/fft_capture_sink_if.sv
// Stream and host read-port signals between the FFT result producer/host and the capture sink.
interface fft_capture_sink_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                     in_valid;
  logic [ADDR_W-1:0]        in_addr;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     in_busy;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_real;
  logic [DATA_W-1:0]        rd_imag;
  logic                     rd_valid;

  modport master (
    output in_valid, in_addr, in_real, in_imag, in_busy, rd_en, rd_addr,
    input  rd_real, rd_imag, rd_valid
  );

  modport slave (
    input  in_valid, in_addr, in_real, in_imag, in_busy, rd_en, rd_addr,
    output rd_real, rd_imag, rd_valid
  );
endinterface

// File: rtl/fft_capture_sink.sv
// Captures the FFT result beat stream into a local buffer, checks address sequencing,
// tracks the peak |re|+|im| and serves host readback once the capture has finished.
module fft_capture_sink #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  fft_capture_sink_if.slave bus,
  output logic              capture_done,
  output logic              capturing,
  output logic              seq_error,
  output logic [ADDR_W:0]   beat_count,
  output logic [DATA_W:0]   peak_mag,
  output logic [ADDR_W-1:0] peak_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                seq_error_q, seq_error_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W:0]     peak_mag_q, peak_mag_d;
  logic [ADDR_W-1:0]   peak_addr_q, peak_addr_d;
  logic [ADDR_W-1:0]   prev_addr_q, prev_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [2*DATA_W-1:0] rd_data_q;

  logic [2*DATA_W-1:0] mem [DEPTH];

  logic                accept;
  logic                rd_hit;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W-1:0]   expected_addr;
  logic [DATA_W:0]     re_ext, im_ext, abs_re, abs_im, mag;

  assign accept        = bus.in_valid && !arm && (state_q == S_ARMED || state_q == S_CAPTURE);
  assign rd_hit        = bus.rd_en && (state_q == S_IDLE || state_q == S_DONE);
  assign count_inc     = count_q + (ADDR_W + 1)'(1);
  assign expected_addr = prev_addr_q + ADDR_W'(1);

  // One extra bit so |-2^(DATA_W-1)| is exact and the sum cannot overflow.
  assign re_ext = {bus.in_real[DATA_W-1], bus.in_real};
  assign im_ext = {bus.in_imag[DATA_W-1], bus.in_imag};
  assign abs_re = re_ext[DATA_W] ? -re_ext : re_ext;
  assign abs_im = im_ext[DATA_W] ? -im_ext : im_ext;
  assign mag    = abs_re + abs_im;

  always_comb begin
    state_d     = state_q;
    busy_d      = bus.in_busy;
    seq_error_d = seq_error_q;
    count_d     = count_q;
    peak_mag_d  = peak_mag_q;
    peak_addr_d = peak_addr_q;
    prev_addr_d = prev_addr_q;
    rd_valid_d  = rd_hit;
    if (arm) begin
      state_d     = S_ARMED;
      busy_d      = 1'b0;
      seq_error_d = 1'b0;
      count_d     = '0;
      peak_mag_d  = '0;
      peak_addr_d = '0;
    end else begin
      if (accept) begin
        count_d     = count_inc;
        prev_addr_d = bus.in_addr;
        if (mag > peak_mag_q) begin
          peak_mag_d  = mag;
          peak_addr_d = bus.in_addr;
        end
        // The first beat only establishes the base address.
        if (state_q == S_CAPTURE && bus.in_addr != expected_addr) begin
          seq_error_d = 1'b1;
        end
      end
      case (state_q)
        S_ARMED: begin
          if (accept) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          if ((accept && count_inc == DEPTH_CNT) || (busy_q && !bus.in_busy)) begin
            state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      seq_error_q <= 1'b0;
      count_q     <= '0;
      peak_mag_q  <= '0;
      peak_addr_q <= '0;
      prev_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      seq_error_q <= seq_error_d;
      count_q     <= count_d;
      peak_mag_q  <= peak_mag_d;
      peak_addr_q <= peak_addr_d;
      prev_addr_q <= prev_addr_d;
      rd_valid_q  <= rd_valid_d;
      if (rd_hit) rd_data_q <= mem[bus.rd_addr];
    end
  end

  // Buffer contents are deliberately not reset; arm and reset leave them alone.
  always_ff @(posedge clk) begin
    if (accept) mem[bus.in_addr] <= {bus.in_real, bus.in_imag};
  end

  assign capture_done = (state_q == S_DONE);
  assign capturing    = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign seq_error    = seq_error_q;
  assign beat_count   = count_q;
  assign peak_mag     = peak_mag_q;
  assign peak_addr    = peak_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_real  = rd_data_q[2*DATA_W-1:DATA_W];
  assign bus.rd_imag  = rd_data_q[DATA_W-1:0];

endmodule

// File: tb/tb_fft_capture_sink.sv
// Self-checking bench for fft_capture_sink: vector table for status behaviour,
// hand-written sequences for the long captures, and a read-data scoreboard.
module tb_fft_capture_sink;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic       capture_done, capturing, seq_error;
  logic [8:0] beat_count;
  logic [16:0] peak_mag;
  logic [7:0] peak_addr;

  fft_capture_sink_if #(.DATA_W(16), .ADDR_W(8)) bus ();

  fft_capture_sink #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .bus          (bus.slave),
    .capture_done (capture_done),
    .capturing    (capturing),
    .seq_error    (seq_error),
    .beat_count   (beat_count),
    .peak_mag     (peak_mag),
    .peak_addr    (peak_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl_mem [256];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        arm;
    logic        valid;
    logic [7:0]  addr;
    logic [15:0] re;
    logic [15:0] im;
    logic        busy;
    logic        acc;
    int          cnt;
    logic        seq;
    int          peak;
    int          paddr;
    logic        done;
    logic        cap;
  } vec_t;

  vec_t vecs [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic add_vec(input logic a, input logic v, input int addr, input int re, input int im,
                         input logic busy, input logic acc, input int cnt, input logic seq,
                         input int peak, input int paddr, input logic done, input logic cap);
    vec_t r;
    r.arm = a; r.valid = v; r.addr = 8'(addr); r.re = 16'(re); r.im = 16'(im);
    r.busy = busy; r.acc = acc; r.cnt = cnt; r.seq = seq; r.peak = peak;
    r.paddr = paddr; r.done = done; r.cap = cap;
    vecs.push_back(r);
  endtask

  task automatic beat(input int addr, input int re, input int im);
    bus.in_valid = 1'b1;
    bus.in_addr  = 8'(addr);
    bus.in_real  = 16'(re);
    bus.in_imag  = 16'(im);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm         = 1'b1;
    bus.in_busy = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // Back-to-back reads; expected words are queued at issue and popped when rd_valid shows.
  task automatic read_run(input int first, input int n, input int stride);
    logic [31:0] e;
    logic [31:0] last;
    last = '0;
    bus.rd_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.rd_addr = 8'(first + k * stride);
      exp_q.push_back(mdl_mem[8'(first + k * stride)]);
      step();
      check($sformatf("rd_valid @%0d", bus.rd_addr), 32'(bus.rd_valid), 32'd1);
      if (bus.rd_valid && exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        last = e;
        check($sformatf("rd_real @%0d", bus.rd_addr), 32'(bus.rd_real), 32'(e[31:16]));
        check($sformatf("rd_imag @%0d", bus.rd_addr), 32'(bus.rd_imag), 32'(e[15:0]));
      end
    end
    bus.rd_en = 1'b0;
    step();
    check("rd_valid idle", 32'(bus.rd_valid), 32'd0);
    check("rd_real hold", 32'(bus.rd_real), 32'(last[31:16]));
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    arm         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr = '0;
    bus.in_real = '0;
    bus.in_imag = '0;
    bus.in_busy = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;

    // Reset state
    step();
    step();
    check("rst capture_done", 32'(capture_done), 32'd0);
    check("rst capturing", 32'(capturing), 32'd0);
    check("rst seq_error", 32'(seq_error), 32'd0);
    check("rst beat_count", 32'(beat_count), 32'd0);
    check("rst peak_mag", 32'(peak_mag), 32'd0);
    check("rst peak_addr", 32'(peak_addr), 32'd0);
    check("rst rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst rd_real", 32'(bus.rd_real), 32'd0);
    rst_n = 1'b1;
    step();

    // Full sequential capture 1..255, ended by in_busy falling
    do_arm();
    check("t1 capturing after arm", 32'(capturing), 32'd1);
    for (int a = 1; a < 256; a++) begin
      beat(a, a, -a);
      mdl_mem[a] = {16'(a), 16'(-a)};
    end
    check("t1 beat_count", 32'(beat_count), 32'd255);
    check("t1 seq_error", 32'(seq_error), 32'd0);
    check("t1 peak_mag", 32'(peak_mag), 32'd510);
    check("t1 peak_addr", 32'(peak_addr), 32'd255);
    check("t1 done before edge", 32'(capture_done), 32'd0);
    bus.in_busy = 1'b0;
    step();
    check("t1 capture_done", 32'(capture_done), 32'd1);
    check("t1 capturing off", 32'(capturing), 32'd0);
    read_run(7, 1, 1);
    read_run(1, 3, 127);

    // Vector table: sequence gap, magnitude extremes/ties, arm collision
    add_vec(1, 0, 0,  0,  0, 1, 0, 0, 0, 0,  0, 0, 1);
    add_vec(0, 1, 0,  0,  0, 1, 1, 1, 0, 0,  0, 0, 1);
    add_vec(0, 1, 1, 10,  1, 1, 1, 2, 0, 11, 1, 0, 1);
    add_vec(0, 1, 2, 20,  2, 1, 1, 3, 0, 22, 2, 0, 1);
    add_vec(0, 1, 4, 40,  4, 1, 1, 4, 1, 44, 4, 0, 1);
    add_vec(0, 1, 5, 50,  5, 1, 1, 5, 1, 55, 5, 0, 1);
    add_vec(0, 0, 0,  0,  0, 0, 0, 5, 1, 55, 5, 1, 0);
    add_vec(1, 0, 0,  0,  0, 1, 0, 0, 0, 0,  0, 0, 1);
    add_vec(0, 1, 3, -32768, -32768, 1, 1, 1, 0, 65536, 3, 0, 1);
    add_vec(0, 1, 4,  32767, -32767, 1, 1, 2, 0, 65536, 3, 0, 1);
    add_vec(0, 1, 5, -32768, -32768, 1, 1, 3, 0, 65536, 3, 0, 1);
    add_vec(0, 1, 6, 1, 1, 0, 1, 4, 0, 65536, 3, 1, 0);
    add_vec(0, 1, 7, 9, 9, 0, 0, 4, 0, 65536, 3, 1, 0);
    add_vec(1, 1, 50, 30000, 30000, 1, 0, 0, 0, 0, 0, 0, 1);
    add_vec(0, 1, 9,  1, 1, 1, 1, 1, 0, 2, 9, 0, 1);
    add_vec(0, 1, 10, 2, 0, 1, 1, 2, 0, 2, 9, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      arm          = vecs[i].arm;
      bus.in_valid = vecs[i].valid;
      bus.in_addr  = vecs[i].addr;
      bus.in_real  = vecs[i].re;
      bus.in_imag  = vecs[i].im;
      bus.in_busy  = vecs[i].busy;
      step();
      if (vecs[i].acc) mdl_mem[vecs[i].addr] = {vecs[i].re, vecs[i].im};
      arm          = 1'b0;
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d beat_count", i), 32'(beat_count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d seq_error", i), 32'(seq_error), 32'(vecs[i].seq));
      check($sformatf("vec%0d peak_mag", i), 32'(peak_mag), 32'(vecs[i].peak));
      check($sformatf("vec%0d peak_addr", i), 32'(peak_addr), 32'(vecs[i].paddr));
      check($sformatf("vec%0d capture_done", i), 32'(capture_done), 32'(vecs[i].done));
      check($sformatf("vec%0d capturing", i), 32'(capturing), 32'(vecs[i].cap));
      if (i == 6) read_run(4, 1, 1);
      if (i == 12) read_run(3, 4, 1);
    end

    // Read requests during CAPTURE are ignored
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'd4;
    step();
    check("cap rd_valid", 32'(bus.rd_valid), 32'd0);
    step();
    check("cap rd_valid 2", 32'(bus.rd_valid), 32'd0);
    bus.rd_en = 1'b0;

    // DEPTH termination with in_busy held high
    do_arm();
    for (int a = 0; a < 256; a++) begin
      beat(a, a + 1000, a);
      mdl_mem[a] = {16'(a + 1000), 16'(a)};
      if (a == 254) begin
        check("t4 count 255", 32'(beat_count), 32'd255);
        check("t4 done early", 32'(capture_done), 32'd0);
      end
    end
    check("t4 beat_count", 32'(beat_count), 32'd256);
    check("t4 capture_done", 32'(capture_done), 32'd1);
    check("t4 capturing", 32'(capturing), 32'd0);
    check("t4 peak_mag", 32'(peak_mag), 32'd1510);
    beat(0, 20000, 20000);
    check("t4 257th count", 32'(beat_count), 32'd256);
    check("t4 257th peak", 32'(peak_mag), 32'd1510);
    check("t4 257th peak_addr", 32'(peak_addr), 32'd255);
    bus.in_busy = 1'b0;
    read_run(0, 3, 127);

    // Reset mid-capture
    do_arm();
    for (int a = 0; a < 10; a++) beat(a, 100, 100);
    check("t6 count before reset", 32'(beat_count), 32'd10);
    rst_n = 1'b0;
    #2;
    check("t6 beat_count", 32'(beat_count), 32'd0);
    check("t6 capturing", 32'(capturing), 32'd0);
    check("t6 peak_mag", 32'(peak_mag), 32'd0);
    check("t6 rd_real", 32'(bus.rd_real), 32'd0);
    check("t6 rd_imag", 32'(bus.rd_imag), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t6 capture_done", 32'(capture_done), 32'd0);
    check("t6 capturing idle", 32'(capturing), 32'd0);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'd0;
    step();
    bus.rd_en = 1'b0;
    check("t6 idle read", 32'(bus.rd_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_capture_sink.md
# fft_capture_sink

Receiving end of the FFT result stream. Consumes the `(valid, addr, real, imag)` beat stream and the `busy` indication produced by the FFT accuracy engine and writes each beat into a local sample buffer. It checks that addresses arrive in sequence and tracks the peak L1 magnitude and the address where it occurred. After the capture completes, a host reads the stored results back through a one-cycle-latency read port.

## Interface
Parameters:
- `DATA_W`, 16, width of the signed two's-complement real/imag components
- `ADDR_W`, 8, width of the stream address and read address
- `DEPTH`, 256, number of buffer entries; must equal 2**ADDR_W

Ports:
- `clk` input 1: single clock, all logic on the rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `arm` input 1: one-cycle pulse that clears status and starts a new capture
- `in_valid` input 1: stream beat qualifier
- `in_addr` input ADDR_W: stream beat address
- `in_real` input DATA_W: stream beat real component, signed
- `in_imag` input DATA_W: stream beat imaginary component, signed
- `in_busy` input 1: producer busy flag
- `rd_en` input 1: host read request
- `rd_addr` input ADDR_W: host read address
- `rd_real` output DATA_W: read data, real
- `rd_imag` output DATA_W: read data, imaginary
- `rd_valid` output 1: read data valid
- `capture_done` output 1: level, high while in DONE
- `capturing` output 1: level, high while in ARMED or CAPTURE
- `seq_error` output 1: sticky address-sequence error
- `beat_count` output ADDR_W+1: number of beats accepted
- `peak_mag` output DATA_W+1: largest |re|+|im| seen, unsigned
- `peak_addr` output ADDR_W: address of the first beat reaching `peak_mag`

## Operation
- **States.**
  - IDLE: after reset.
  - ARMED: waiting for the first beat.
  - CAPTURE: accepting beats.
  - DONE: capture finished.
- **arm.**
  - Valid in any state; moves the block to ARMED.
  - Clears `beat_count`, `seq_error`, `peak_mag`, `peak_addr` and the previous-busy register.
  - Does not clear buffer contents.
  - If `arm` and `in_valid` are both high in the same cycle, `arm` wins and the beat is dropped.
- **ARMED.** The first `in_valid` beat is accepted and the state moves to CAPTURE. That beat's address sets the expected-address base; no sequence check is made on it.
- **CAPTURE, for each `in_valid` beat:**
  - Write `{in_real, in_imag}` to buffer[`in_addr`].
  - Increment `beat_count`.
  - If `in_addr` ≠ previous address + 1 (mod DEPTH), set `seq_error` (sticky). The data is still written at `in_addr`.
- **Magnitude.**
  - mag = |re| + |im|, computed in DATA_W+1 bits; |−2^(DATA_W−1)| = 2^(DATA_W−1) with no saturation.
  - Update `peak_mag`/`peak_addr` only if mag > `peak_mag` (strict), so the first occurrence is kept.
  - Beats in ARMED (the first beat) also update the peak.
- **End of capture.** CAPTURE → DONE when either:
  - the registered `in_busy` was 1 and `in_busy` is now 0 (falling edge); or
  - `beat_count` reaches DEPTH after a write.
- **Beat on the ending edge.** A beat that coincides with the `in_busy` falling edge is accepted first, then the state moves to DONE.
- **DONE.** Further beats are ignored: no writes, no count or peak changes.
- **Reads.**
  - Honoured only in IDLE or DONE.
  - `rd_en` in ARMED or CAPTURE is ignored and `rd_valid` stays 0.
  - Entries never written return prior contents; the value after reset is undefined.

## Timing
- **Reset values:**
  - state IDLE
  - `rd_valid`, `capture_done`, `capturing`, `seq_error`: 0
  - `beat_count`, `peak_mag`, `peak_addr`, `rd_real`, `rd_imag`: 0
- **Beat latency.** A beat sampled at edge N updates `beat_count`, `seq_error` and the peak outputs after edge N; all are visible in cycle N+1.
- **State outputs.**
  - `capture_done` rises in the cycle after the edge that samples the end condition.
  - `capturing` falls in that same cycle.
- **arm latency.** `arm` at edge N makes `capturing` = 1 and clears status in cycle N+1.
- **Reads.**
  - `rd_en` at edge N gives `rd_valid` = 1 with data in cycle N+1; reads can be issued back-to-back every cycle.
  - `rd_real`/`rd_imag` hold their last value when `rd_valid` = 0.
- **Reset mid-capture.** Asynchronously forces all reset values; buffer contents are not guaranteed.
- **Count limits.** `beat_count` saturates at DEPTH, since DONE blocks further increments.

## Test plan
- **Full sequential capture.**
  - Stimulus: `arm`; then addresses 1..255 with re=addr, im=−addr; then `in_busy` falls.
  - Required: `beat_count`=255, `seq_error`=0, `peak_mag`=510, `peak_addr`=255, `capture_done`=1 one cycle after the falling edge.
  - Readback: addr 7 → rd_real=7, rd_imag=−7 one cycle after `rd_en`.
- **Sequence gap.**
  - Stimulus: addresses 0,1,2,4,5, then `in_busy` falls.
  - Required: `seq_error`=1 from the cycle after the addr-4 beat; buffer[4] holds the addr-4 data; `beat_count`=5.
- **Magnitude extremes and ties.**
  - Stimulus: beats (−32768, −32768) at addr 3 and (32767, −32767) at addr 4.
  - Required: `peak_mag`=65536, `peak_addr`=3.
  - A later beat with an equal magnitude leaves `peak_addr` at 3.
- **DEPTH termination and DONE behaviour.**
  - Stimulus: 256 contiguous beats with `in_busy` held high.
  - Required: DONE after the 256th beat, `beat_count`=256; a 257th beat changes nothing.
- **arm collision and reads during capture.**
  - Stimulus 1: `arm` and `in_valid` in the same cycle. Required: the beat is not counted and the state is ARMED.
  - Stimulus 2: `rd_en` in CAPTURE. Required: `rd_valid` stays 0.
- **Reset mid-capture.**
  - Stimulus: deassert `rst_n` after 10 beats.
  - Required: all outputs return to 0 immediately and the state is IDLE.
